uart_dbg_cmd_decoder: RTL and testbench

Sits directly downstream of the UART receiver. Consumes its byte stream and parses debugger command frames (sync, opcode, address, optional data, checksum). Executes each frame as a one-cycle register read or write on a simple 8-bit debug register bus. Hands a single response byte to the UART transmitter over a valid/ready handshake.

---
 rtl/uart_dbg_cmd_decoder_pkg.sv | 28 ++
 rtl/uart_dbg_cmd_decoder_if.sv | 31 +++
 rtl/uart_dbg_cmd_decoder_timeout.sv | 39 +++
 rtl/uart_dbg_cmd_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_uart_dbg_cmd_decoder.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_dbg_cmd_decoder_pkg.sv
// Shared types and constants for the UART debug command decoder: FSM state
// encoding, opcode and response byte values.
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPC    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_EXEC   = 3'd5,
    ST_RDWAIT = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_RD   = 8'h02;
  localparam logic [7:0] OP_PING = 8'h03;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] RSP_PING = 8'h5A;

  function automatic logic op_is_known(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_RD) || (op == OP_PING);
  endfunction

endpackage

// File: rtl/uart_dbg_cmd_decoder_if.sv
// Byte-stream, debug register bus and response handshake between the
// decoder and its neighbours (UART receiver/transmitter, register file).
interface uart_dbg_cmd_decoder_if;

  // rx: one-cycle rx_valid strobe per byte, no back-pressure.
  // tx: tx_byte transfers on a cycle with tx_valid & tx_ready; while tx_valid
  //     is high and tx_ready low, tx_byte is held stable.
  // reg: reg_we/reg_re are one-cycle strobes; reg_rdata is valid exactly one
  //      cycle after reg_re.
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport slave (
    input  rx_byte, rx_valid, reg_rdata, tx_ready,
    output reg_addr, reg_wdata, reg_we, reg_re, tx_byte, tx_valid
  );

  modport master (
    output rx_byte, rx_valid, reg_rdata, tx_ready,
    input  reg_addr, reg_wdata, reg_we, reg_re, tx_byte, tx_valid
  );

endinterface

// File: rtl/uart_dbg_cmd_decoder_timeout.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES is reached.
module dbg_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Outside the frame-collecting states the count is parked at zero so a new
  // frame always starts with a full window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_dbg_cmd_decoder.sv
// Debug command frame parser: SYNC, OPC, [ADDR], [DATA], CSUM frames become a
// single register read/write, answered with one response byte.
module uart_dbg_cmd_decoder
  import uart_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 iCE_CLK,
  input  logic                 RSTN,
  uart_dbg_cmd_decoder_if.slave bus,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count,
  output state_t              dbg_state
);

  state_t               state_q, state_d;
  logic [7:0]           opc_q, opc_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           csum_q, csum_d;
  logic                 bad_op_q, bad_op_d;
  logic                 nak_q, nak_d;
  logic [7:0]           reg_addr_q, reg_addr_d;
  logic [7:0]           reg_wdata_q, reg_wdata_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 err_inc;
  logic                 tmo_enable;
  logic                 tmo_expired;

  assign tmo_enable = (state_q == ST_OPC) || (state_q == ST_ADDR) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);

  dbg_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (iCE_CLK),
    .rstn   (RSTN),
    .clear  (bus.rx_valid),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    addr_d      = addr_q;
    data_d      = data_q;
    csum_d      = csum_q;
    bad_op_d    = bad_op_q;
    nak_d       = nak_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    tx_byte_d   = tx_byte_q;
    err_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) begin
          state_d  = ST_OPC;
          csum_d   = 8'h00;
          bad_op_d = 1'b0;
          nak_d    = 1'b0;
        end
      end

      ST_OPC: begin
        if (bus.rx_valid) begin
          opc_d    = bus.rx_byte;
          csum_d   = csum_q ^ bus.rx_byte;
          bad_op_d = !op_is_known(bus.rx_byte);
          if ((bus.rx_byte == OP_WR) || (bus.rx_byte == OP_RD)) begin
            state_d = ST_ADDR;
          end else begin
            state_d = ST_CSUM;
          end
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (bus.rx_valid) begin
          addr_d  = bus.rx_byte;
          csum_d  = csum_q ^ bus.rx_byte;
          state_d = (opc_q == OP_WR) ? ST_DATA : ST_CSUM;
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (bus.rx_valid) begin
          data_d  = bus.rx_byte;
          csum_d  = csum_q ^ bus.rx_byte;
          state_d = ST_CSUM;
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
        end
      end

      // Rejected frames still pass through EXEC (without a strobe) so every
      // non-read response appears a fixed two cycles after the CSUM byte.
      ST_CSUM: begin
        if (bus.rx_valid) begin
          state_d = ST_EXEC;
          if ((bus.rx_byte != csum_q) || bad_op_q) begin
            nak_d   = 1'b1;
            err_inc = 1'b1;
          end else if ((opc_q == OP_WR) || (opc_q == OP_RD)) begin
            reg_addr_d = addr_q;
            if (opc_q == OP_WR) begin
              reg_wdata_d = data_q;
            end
          end
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        err_inc = bus.rx_valid;
        if (nak_q) begin
          tx_byte_d = RSP_NAK;
          state_d   = ST_RESP;
        end else if (opc_q == OP_WR) begin
          tx_byte_d = RSP_ACK;
          state_d   = ST_RESP;
        end else if (opc_q == OP_RD) begin
          state_d = ST_RDWAIT;
        end else begin
          tx_byte_d = RSP_PING;
          state_d   = ST_RESP;
        end
      end

      ST_RDWAIT: begin
        err_inc   = bus.rx_valid;
        tx_byte_d = bus.reg_rdata;
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        err_inc = bus.rx_valid;
        if (bus.tx_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != {ERR_CNT_W{1'b1}})) begin
      err_d = err_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge iCE_CLK) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      opc_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      csum_q      <= 8'h00;
      bad_op_q    <= 1'b0;
      nak_q       <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      tx_byte_q   <= 8'h00;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      csum_q      <= csum_d;
      bad_op_q    <= bad_op_d;
      nak_q       <= nak_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      tx_byte_q   <= tx_byte_d;
      err_q       <= err_d;
    end
  end

  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = (state_q == ST_EXEC) && !nak_q && (opc_q == OP_WR);
  assign bus.reg_re    = (state_q == ST_EXEC) && !nak_q && (opc_q == OP_RD);
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_valid  = (state_q == ST_RESP);
  assign busy          = (state_q != ST_IDLE);
  assign err_count     = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_dbg_cmd_decoder.sv
// Bench for uart_dbg_cmd_decoder: directed frames from the test plan followed
// by random frames, checked against a frame-level model of the protocol.
module tb_uart_dbg_cmd_decoder;
  import uart_dbg_pkg::*;

  localparam int TMO = 50;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_dbg_cmd_decoder_if bus ();
  logic       busy;
  logic [7:0] err_count;
  state_t     dbg_state;

  uart_dbg_cmd_decoder #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_BYTE     (8'hA5),
    .ERR_CNT_W     (8)
  ) dut (
    .iCE_CLK  (clk),
    .RSTN     (rstn),
    .bus      (bus),
    .busy     (busy),
    .err_count(err_count),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] bus_mem[256];
  logic [7:0] exp_mem[256];
  int         exp_err = 0;
  int         m_kind;
  logic [7:0] m_addr, m_data;

  localparam int K_NAK = 0, K_WR = 1, K_RD = 2, K_PING = 3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void err_bump();
    if (exp_err < 255) exp_err++;
  endfunction

  // Frame-level reference: decide the outcome from the frame's bytes alone.
  function automatic void model_frame();
    int         n;
    logic [7:0] x;
    logic [7:0] op;
    bit         ok;
    n  = frame_q.size();
    op = frame_q[1];
    x  = 8'h00;
    for (int i = 1; i < n - 1; i++) x ^= frame_q[i];
    ok = (op == 8'h01 || op == 8'h02 || op == 8'h03) && (x == frame_q[n-1]);
    if (!ok) begin
      m_kind = K_NAK;
      exp_q.push_back(8'h15);
      err_bump();
    end else if (op == 8'h01) begin
      m_kind = K_WR;
      m_addr = frame_q[2];
      m_data = frame_q[3];
      exp_mem[m_addr] = m_data;
      exp_q.push_back(8'h06);
    end else if (op == 8'h02) begin
      m_kind = K_RD;
      m_addr = frame_q[2];
      exp_q.push_back(exp_mem[m_addr]);
    end else begin
      m_kind = K_PING;
      exp_q.push_back(8'h5A);
    end
  endfunction

  function automatic void mk_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] x;
    frame_q = {};
    frame_q.push_back(8'hA5);
    frame_q.push_back(op);
    x = op;
    if (op == 8'h01 || op == 8'h02) begin
      frame_q.push_back(a);
      x ^= a;
    end
    if (op == 8'h01) begin
      frame_q.push_back(d);
      x ^= d;
    end
    frame_q.push_back(x);
  endfunction

  // driver tasks (all called at a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'($urandom);
  endtask

  task automatic drop_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_byte  = 8'($urandom);
      bus.rx_valid = 1'b1;
      @(negedge clk);
      err_bump();
    end
    bus.rx_valid = 1'b0;
  endtask

  // Sends frame_q and checks the whole transaction through to the handshake.
  task automatic run_frame(input int gmin, input int gmax, input int hold, input int n_drop);
    logic [7:0] rd_addr;
    logic [7:0] rsp;
    model_frame();
    foreach (frame_q[i]) begin
      idle($urandom_range(gmin, gmax));
      send_byte(frame_q[i]);
    end
    chk("reg_we", bus.reg_we, m_kind == K_WR);
    chk("reg_re", bus.reg_re, m_kind == K_RD);
    chk("tx_valid_early", bus.tx_valid, 0);
    if (m_kind == K_WR) begin
      chk("wr_addr", bus.reg_addr, m_addr);
      chk("wr_data", bus.reg_wdata, m_data);
      bus_mem[bus.reg_addr] = bus.reg_wdata;
    end
    if (m_kind == K_RD) chk("rd_addr", bus.reg_addr, m_addr);
    rd_addr = bus.reg_addr;
    @(negedge clk);
    chk("we_one_cycle", bus.reg_we | bus.reg_re, 0);
    if (m_kind == K_RD) begin
      chk("tx_valid_rdwait", bus.tx_valid, 0);
      bus.reg_rdata = bus_mem[rd_addr];
      @(negedge clk);
      bus.reg_rdata = 8'($urandom);
    end
    rsp = exp_q.pop_front();
    chk("tx_valid", bus.tx_valid, 1);
    chk("tx_byte", bus.tx_byte, rsp);
    chk("busy_resp", busy, 1);
    drop_bytes(n_drop);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("tx_valid_hold", bus.tx_valid, 1);
      chk("tx_byte_hold", bus.tx_byte, rsp);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    chk("tx_valid_drop", bus.tx_valid, 0);
    chk("busy_idle", busy, 0);
    chk("err_count", err_count, exp_err);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_reg_addr", bus.reg_addr, 0);
    chk("rst_reg_wdata", bus.reg_wdata, 0);
    chk("rst_reg_we", bus.reg_we, 0);
    chk("rst_reg_re", bus.reg_re, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_count, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    bus.rx_byte   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.reg_rdata = 8'h00;
    bus.tx_ready  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      exp_mem[i] = bus_mem[i];
    end
    bus_mem[8'h20] = 8'h5B;
    exp_mem[8'h20] = 8'h5B;

    // reset
    idle(3);
    chk_reset_outputs();
    rstn = 1'b1;
    idle(2);

    // 1. write frame, immediate accept
    frame_q = '{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D};
    run_frame(0, 0, 0, 0);

    // 2. read frame, transmitter stalls for 10 cycles
    frame_q = '{8'hA5, 8'h02, 8'h20, 8'h22};
    run_frame(0, 2, 10, 0);

    // 3. bad checksum then bad opcode
    frame_q = '{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00};
    run_frame(0, 0, 0, 0);
    frame_q = '{8'hA5, 8'h07, 8'h07};
    run_frame(0, 1, 2, 0);

    // idle garbage is ignored silently
    for (int i = 0; i < 8; i++) begin
      logic [7:0] g;
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
    chk("garbage_busy", busy, 0);
    chk("garbage_err", err_count, exp_err);

    // 4. timeout abandons a stalled frame, then ping works
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(60);
    chk("tmo_busy", busy, 0);
    chk("tmo_tx_valid", bus.tx_valid, 0);
    chk("tmo_err", err_count, exp_err);
    frame_q = '{8'hA5, 8'h03, 8'h03};
    run_frame(0, 0, 0, 0);

    // long but legal inter-byte gaps keep the frame alive
    mk_frame(8'h01, 8'h44, 8'hC3);
    run_frame(45, 45, 0, 0);

    // SYNC value inside a frame is ordinary data
    mk_frame(8'h01, 8'hA5, 8'hA5);
    run_frame(0, 1, 0, 0);

    // 5. overrun while response pending, then saturation
    mk_frame(8'h02, 8'h44, 8'h00);
    run_frame(0, 0, 3, 1);
    mk_frame(8'h03, 8'h00, 8'h00);
    run_frame(0, 0, 2, 300);
    chk("err_saturated", err_count, 8'hFF);

    // rx byte and tx accept in the same RESP cycle
    mk_frame(8'h03, 8'h00, 8'h00);
    model_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    @(negedge clk);
    chk("simul_tx_byte", bus.tx_byte, exp_q.pop_front());
    bus.rx_byte  = 8'h77;
    bus.rx_valid = 1'b1;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    err_bump();
    chk("simul_tx_valid", bus.tx_valid, 0);
    chk("simul_err", err_count, exp_err);

    // 6. reset mid-frame discards everything
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    rstn = 1'b0;
    idle(2);
    chk_reset_outputs();
    rstn = 1'b1;
    exp_err = 0;
    idle(1);
    frame_q = '{8'hA5, 8'h02, 8'h20, 8'h22};
    run_frame(0, 0, 0, 0);

    // random frames
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 4);
      case (kind)
        0: mk_frame(8'h01, 8'($urandom), 8'($urandom));
        1: mk_frame(8'h02, 8'($urandom), 8'h00);
        2: mk_frame(8'h03, 8'h00, 8'h00);
        3: begin
          mk_frame(8'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
          frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] ^ 8'($urandom_range(1, 255));
        end
        default: begin
          logic [7:0] op;
          op = 8'($urandom_range(4, 255));
          frame_q = {};
          frame_q.push_back(8'hA5);
          frame_q.push_back(op);
          frame_q.push_back(op);
        end
      endcase
      run_frame(0, 3, $urandom_range(0, 4), $urandom_range(0, 1));
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
